// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR display project.
// Provides the LFSR width, the debounce-length rule and the load-request
// payload used between the input conditioner and its strobe scheduler.
package lfsr_pkg;

    localparam int unsigned LFSR_BITS = 5;

    // Pending load requests, one flag per load target.
    typedef struct packed {
        logic seed;
        logic taps;
    } load_req_t;

    // Number of clock cycles a button must be stable, never less than one.
    function automatic int unsigned debounce_cycles(input int unsigned clock_hz,
                                                    input int unsigned ms);
        int unsigned c;
        c = (clock_hz * ms) / 1000;
        return (c == 0) ? 1 : c;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a counting debouncer and rising-edge
// detector for one raw pushbutton.
// Ports:
//   clk     - project clock, rising edge
//   reset_n - synchronous active-low reset
//   raw     - asynchronous bouncy button, active high
//   level   - debounced button level
//   rise    - high for one cycle after the debounced level goes 0->1
module debounce_sync #(
    parameter int unsigned CYCLES = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             s_q, s_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q, stable_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Stable level only moves after the synchronised input has disagreed
    // with it on CYCLES consecutive edges; any agreement restarts the count.
    always_comb begin
        sync1_d      = raw;
        s_d          = sync1_q;
        stable_d     = stable_q;
        stable_dly_d = stable_q;
        cnt_d        = cnt_q;
        if (s_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(CYCLES - 1)) begin
            stable_d = s_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            s_q          <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            s_q          <= s_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            cnt_q        <= cnt_d;
        end
    end

    assign level = stable_q;
    assign rise  = stable_q & ~stable_dly_q;

endmodule

// File: rtl/lfsr_input_conditioner.sv
// Board-pin front end for the LFSR: debounces the "load seed" and
// "load taps" buttons, synchronises the data switches and issues exactly
// one registered load strobe per accepted press with a captured data word.
// Ports:
//   clk          - project clock, rising edge
//   reset_n      - synchronous active-low reset
//   btn_seed_raw - raw "load seed" button, active high
//   btn_taps_raw - raw "load taps" button, active high
//   data_raw     - raw data switches
//   load_seed    - one-cycle strobe, load data_out into the LFSR state
//   load_taps    - one-cycle strobe, load data_out into the tap register
//   data_out     - captured switch word, held between captures
module lfsr_input_conditioner
    import lfsr_pkg::*;
#(
    parameter int unsigned CLOCK_HZ    = 1000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned DATA_BITS   = LFSR_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 btn_seed_raw,
    input  logic                 btn_taps_raw,
    input  logic [DATA_BITS-1:0] data_raw,
    output logic                 load_seed,
    output logic                 load_taps,
    output logic [DATA_BITS-1:0] data_out
);

    localparam int unsigned DEBOUNCE_CYCLES = debounce_cycles(CLOCK_HZ, DEBOUNCE_MS);

    logic seed_level, seed_rise;
    logic taps_level, taps_rise;
    logic seed_go, taps_go;

    logic [DATA_BITS-1:0] data_s1_q, data_s1_d;
    logic [DATA_BITS-1:0] data_s_q, data_s_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 load_seed_q, load_seed_d;
    logic                 load_taps_q, load_taps_d;
    load_req_t            pend_q, pend_d;

    debounce_sync #(.CYCLES(DEBOUNCE_CYCLES)) u_seed (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_seed_raw),
        .level   (seed_level),
        .rise    (seed_rise)
    );

    debounce_sync #(.CYCLES(DEBOUNCE_CYCLES)) u_taps (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_taps_raw),
        .level   (taps_level),
        .rise    (taps_rise)
    );

    // A rise always coincides with a high level; the level term just keeps
    // the press qualification explicit.
    assign seed_go = seed_rise & seed_level;
    assign taps_go = taps_rise & taps_level;

    // Strobe scheduler: pending requests drain first, one strobe per cycle.
    // Data is captured only when a fresh press is issued immediately;
    // deferred strobes reuse the word already on data_out.
    always_comb begin
        data_s1_d   = data_raw;
        data_s_d    = data_s1_q;
        data_out_d  = data_out_q;
        load_seed_d = 1'b0;
        load_taps_d = 1'b0;
        pend_d      = pend_q;
        if (pend_q.seed) begin
            load_seed_d = 1'b1;
            pend_d.seed = 1'b0;
            if (taps_go) begin
                pend_d.taps = 1'b1;
            end
        end else if (pend_q.taps) begin
            load_taps_d = 1'b1;
            pend_d.taps = 1'b0;
            if (seed_go) begin
                pend_d.seed = 1'b1;
            end
        end else if (taps_go) begin
            load_taps_d = 1'b1;
            data_out_d  = data_s_q;
            pend_d.seed = seed_go;
        end else if (seed_go) begin
            load_seed_d = 1'b1;
            data_out_d  = data_s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_s1_q   <= '0;
            data_s_q    <= '0;
            data_out_q  <= '0;
            load_seed_q <= 1'b0;
            load_taps_q <= 1'b0;
            pend_q      <= '0;
        end else begin
            data_s1_q   <= data_s1_d;
            data_s_q    <= data_s_d;
            data_out_q  <= data_out_d;
            load_seed_q <= load_seed_d;
            load_taps_q <= load_taps_d;
            pend_q      <= pend_d;
        end
    end

    assign load_seed = load_seed_q;
    assign load_taps = load_taps_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_lfsr_input_conditioner.sv
// Scoreboard bench for lfsr_input_conditioner with a behavioural model of
// button acceptance and strobe ordering.
module tb_lfsr_input_conditioner;

    localparam int N  = 5;
    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          btn_seed_raw;
    logic          btn_taps_raw;
    logic [DW-1:0] data_raw;
    logic          load_seed;
    logic          load_taps;
    logic [DW-1:0] data_out;

    always #5 clk = ~clk;

    lfsr_input_conditioner #(
        .CLOCK_HZ    (1000),
        .DEBOUNCE_MS (5),
        .DATA_BITS   (DW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_seed_raw (btn_seed_raw),
        .btn_taps_raw (btn_taps_raw),
        .data_raw     (data_raw),
        .load_seed    (load_seed),
        .load_taps    (load_taps),
        .data_out     (data_out)
    );

    typedef struct {
        bit            is_seed;
        logic [DW-1:0] data;
        int            edge_no;
    } evt_t;

    evt_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   edge_cnt = 0;
    bit   last_rst = 1'b1;
    int   last_seed_edge = -1;
    int   last_taps_edge = -1;
    logic [DW-1:0] held_data = '0;

    // Model state: per button (0 = seed, 1 = taps) the raw history,
    // accepted level and length of the current disagreement run.
    bit   h1[2], h2[2], stab[2], stab_prev[2];
    int   run[2];
    logic [DW-1:0] dh1, dh2, m_data;
    bit   pend[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edge_cnt);
        end
    endtask

    // One clock edge of the reference model, using the inputs present at it.
    task automatic model_edge();
        bit   rise[2];
        bit   raw[2];
        bit   was_empty;
        bit   k;
        evt_t e;
        edge_cnt++;
        if (!reset_n) begin
            last_rst = 1'b1;
            for (int b = 0; b < 2; b++) begin
                h1[b] = 0; h2[b] = 0; stab[b] = 0; stab_prev[b] = 0; run[b] = 0;
            end
            dh1 = '0; dh2 = '0; m_data = '0;
            pend.delete();
            return;
        end
        last_rst = 1'b0;
        raw[0] = btn_seed_raw;
        raw[1] = btn_taps_raw;
        for (int b = 0; b < 2; b++) rise[b] = stab[b] & ~stab_prev[b];
        was_empty = (pend.size() == 0);
        if (rise[1]) pend.push_back(1'b0);
        if (rise[0]) pend.push_back(1'b1);
        if (pend.size() > 0) begin
            k = pend.pop_front();
            if (was_empty) m_data = dh2;
            e.is_seed = k;
            e.data    = m_data;
            e.edge_no = edge_cnt;
            sb_q.push_back(e);
        end
        for (int b = 0; b < 2; b++) begin
            stab_prev[b] = stab[b];
            if (h2[b] == stab[b]) run[b] = 0;
            else if (run[b] + 1 == N) begin
                stab[b] = h2[b];
                run[b]  = 0;
            end else run[b]++;
            h2[b] = h1[b];
            h1[b] = raw[b];
        end
        dh2 = dh1;
        dh1 = data_raw;
    endtask

    // Monitor: compares every presented strobe against the scoreboard head.
    always @(negedge clk) begin
        evt_t e;
        if (last_rst) begin
            chk("reset_outputs", {load_seed, load_taps, data_out}, '0);
            held_data      = '0;
            last_seed_edge = -1;
            last_taps_edge = -1;
        end else begin
            chk("exclusive", 32'(load_seed & load_taps), 0);
            if (load_seed | load_taps) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_strobe", {load_seed, load_taps}, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("strobe_kind", 32'(load_seed), 32'(e.is_seed));
                    chk("strobe_data", data_out, e.data);
                    chk("strobe_edge", edge_cnt, e.edge_no);
                    held_data = e.data;
                end
                if (load_seed) last_seed_edge = edge_cnt;
                if (load_taps) last_taps_edge = edge_cnt;
            end else begin
                chk("data_hold", data_out, held_data);
                if (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
                    chk("missing_strobe", 32'(sb_q[0].edge_no), 32'hFFFF_FFFF);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    task automatic step(input bit rst, input bit s, input bit t);
        reset_n      = rst;
        btn_seed_raw = s;
        btn_taps_raw = t;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit s, input bit t);
        for (int i = 0; i < n; i++) step(1'b1, s, t);
    endtask

    initial begin
        int p;
        bit rs, rt;
        int sl, tl;
        reset_n = 1'b0; btn_seed_raw = 1'b1; btn_taps_raw = 1'b1; data_raw = '0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        idle(12, 1'b0, 1'b0);

        // Clean press
        data_raw = 5'b10110;
        idle(3, 1'b0, 1'b0);
        p = edge_cnt + 1;
        idle(20, 1'b1, 1'b0);
        idle(15, 1'b0, 1'b0);
        chk("clean_latency", last_seed_edge, p + 7);
        chk("clean_data", data_out, 5'b10110);

        // Bouncing taps button
        last_taps_edge = -1;
        step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b0);
        p = edge_cnt + 1;
        idle(30, 1'b0, 1'b1);
        idle(15, 1'b0, 1'b0);
        chk("bounce_latency", last_taps_edge, p + 7);

        // Simultaneous press
        data_raw = 5'b00011;
        idle(3, 1'b0, 1'b0);
        p = edge_cnt + 1;
        idle(20, 1'b1, 1'b1);
        idle(15, 1'b0, 1'b0);
        chk("simul_taps_edge", last_taps_edge, p + 7);
        chk("simul_seed_edge", last_seed_edge, p + 8);

        // Data isolation
        data_raw = 5'b01010;
        idle(3, 1'b0, 1'b0);
        idle(15, 1'b1, 1'b0);
        idle(10, 1'b0, 1'b0);
        data_raw = 5'b11111;
        idle(30, 1'b0, 1'b0);
        chk("data_isolation", data_out, 5'b01010);

        // Reset mid-debounce
        idle(3, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        p = edge_cnt + 1;
        idle(20, 1'b1, 1'b0);
        idle(15, 1'b0, 1'b0);
        chk("reset_restart_latency", last_seed_edge, p + 7);

        // Randomised presses, bounces, data churn and occasional resets
        rs = 0; rt = 0; sl = 0; tl = 0;
        for (int i = 0; i < 2000; i++) begin
            if (sl == 0) begin rs = ~rs; sl = $urandom_range(1, 25); end else sl--;
            if (tl == 0) begin rt = ~rt; tl = $urandom_range(1, 25); end else tl--;
            if ($urandom_range(0, 7) == 0) data_raw = DW'($urandom);
            step(($urandom_range(0, 299) != 0), rs, rt);
        end
        idle(25, 1'b0, 1'b0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_input_conditioner.md
Name: lfsr_input_conditioner

Overview:
- Front-end stage that feeds the LFSR display block.
- Takes raw, asynchronous, bouncy pushbuttons ("load seed", "load taps") and 5 data switches from the board pins.
- Produces clean single-cycle load strobes plus a stable data word, so the LFSR sees exactly one load per physical press.
- Runs on the same slow project clock as the LFSR.

Parameters:
- CLOCK_HZ, 1000, project clock frequency in Hz.
- DEBOUNCE_MS, 20, required stable time of a button before it is accepted.
- DATA_BITS, 5, width of the switch data word; matches the LFSR width.
- Derived localparam DEBOUNCE_CYCLES = max(1, CLOCK_HZ*DEBOUNCE_MS/1000).

Ports:
- clk  input  1  project clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- btn_seed_raw  input  1  asynchronous raw "load seed" button, active high.
- btn_taps_raw  input  1  asynchronous raw "load taps" button, active high.
- data_raw  input  DATA_BITS  asynchronous raw data switches.
- load_seed  output  1  one-cycle strobe: load data_out into the LFSR state.
- load_taps  output  1  one-cycle strobe: load data_out into the tap register.
- data_out  output  DATA_BITS  captured switch word; stable while any strobe is high and until the next capture.

Behaviour:
- Reset: while reset_n=0 at a clk edge, all state clears: sync flops, debounced levels, counters, pending flag, load_seed, load_taps and data_out all go to 0. Reset mid-debounce discards partial counts.
- Synchronisation: each button and each data bit passes through a 2-flop synchroniser (s = second flop).
- Debounce, per button, with state stable (1 bit) and counter cnt (width clog2(DEBOUNCE_CYCLES+1)):
  - If s == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s and cnt <= 0.
  - Else: cnt <= cnt+1.
  - So stable follows s only after s has differed from it on DEBOUNCE_CYCLES consecutive edges. Any glitch back restarts the count.
- Edge detection: rise = stable & ~stable_d. Releases (falling edges) produce no strobe.
- Strobe issue (registered):
  - rise_taps only: load_taps=1 next cycle; data_out <= synchronised data that same edge.
  - rise_seed only, no pending seed: load_seed=1 next cycle; data_out captured the same way.
  - Both rising on the same edge: load_taps first. pending_seed <= 1. Next cycle load_seed=1 with data_out unchanged (no recapture).
  - pending_seed, if set, has priority over a new rise_taps. A rise_taps arriving while pending_seed is set is issued the following cycle via its own pending_taps flag.
  - load_seed and load_taps are never high in the same cycle.
- Latency: raw button rising and held clean is sampled at edge 0. load_* is high in the cycle following edge 2+DEBOUNCE_CYCLES, i.e. total 3+DEBOUNCE_CYCLES cycles from raw to strobe.
- Pulse width: exactly 1 cycle per accepted press, however long the button is held.
- Button held across reset release: stable starts at 0, so after DEBOUNCE_CYCLES a strobe is issued. This is required behaviour.
- data_out holds its value between strobes; switch changes without a strobe are invisible downstream.

Decomposition:
- Shared package lfsr_pkg:
  - LFSR_BITS=5, used as the DATA_BITS default and also by the LFSR block.
  - Function debounce_cycles(clock_hz, ms) implementing the max(1, …) rule.
- Sub-module debounce_sync (parameter CYCLES; ports clk, reset_n, raw, level, rise) is instantiated twice.
- Data synchronisers stay inline.

Test Plan (CLOCK_HZ=1000, DEBOUNCE_MS=5, so DEBOUNCE_CYCLES=5):
- Reset: hold reset_n=0 for 3 cycles with buttons high → load_seed=load_taps=0 and data_out=0 throughout reset.
- Clean press: data_raw=5'b10110, btn_seed_raw 0→1 sampled at edge 0 and held 20 cycles → load_seed=1 exactly in cycle 8 only, data_out=5'b10110, load_taps=0 throughout.
- Bounce: btn_taps_raw toggles 1,0,1,0 on alternating cycles, then stays 1 → no strobe during bouncing. Single load_taps exactly 8 cycles after the final 0→1; release after 30 cycles produces no strobe.
- Simultaneous: data_raw=5'b00011, both buttons rise on the same edge → load_taps in cycle 8, load_seed in cycle 9, data_out=5'b00011 in both; never both high together.
- Data isolation: after a strobe with data 5'b01010, change data_raw to 5'b11111 with no press → data_out stays 5'b01010 indefinitely.
- Reset mid-debounce: press seed, assert reset_n=0 at cycle 4 for 1 cycle while still pressed → no strobe at cycle 8. Strobe comes 3+5 cycles after reset release, i.e. the count restarts.
